bit_serial_alu: RTL

- Multi-cycle WIDTH-bit ALU that computes one bit per clock, LSB first, using a single 1-bit slice datapath. The slice logic is: B conditionally inverted by control[0], a full adder, a 2-bit-select logic unit, and an arith/logic mux.
- This block is the sequencing side of the slice interface. It latches operands, presents bit i with the fed-back carry each cycle, and assembles the result word and flags.
- It is a low-area alternative to the ripple-carry ALU, used by the multi-cycle datapath.

---
 rtl/bit_serial_alu.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one result bit per clock, LSB first, through a 1-bit slice.
// Optional signed-overflow flag is built only when BIT_SERIAL_ALU_OVERFLOW_EN is defined.
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctl_q;

  logic             accept;
  logic             last;
  logic             arith;

  logic             bit_a;
  logic             bit_b;
  logic             bit_bx;
  logic             sum;
  logic             cout;
  logic             lres;
  logic             res;

  // A new op is taken only when the sequencer is not busy
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == LAST);
  assign arith  = ~ctl_q[2];

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (out == '0);

  // One-bit slice: B inversion, full adder, logic unit, result mux
  always_comb begin
    bit_a  = a_q[idx];
    bit_b  = b_q[idx];
    bit_bx = bit_b ^ ctl_q[0];
    sum    = bit_a ^ bit_bx ^ carry;
    cout   = (bit_a & bit_bx) | (bit_a & carry) | (bit_bx & carry);
    lres   = 1'b0;
    case (ctl_q[1:0])
      2'b00:   lres = bit_a & bit_b;
      2'b01:   lres = bit_a | bit_b;
      2'b10:   lres = ~(bit_a | bit_b);
      default: lres = bit_a ^ bit_b;
    endcase
    res = arith ? sum : lres;
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture on an accepted start; later input changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      ctl_q <= '0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      ctl_q <= control;
    end
  end

  // Bit index and fed-back carry
  always_ff @(posedge clk) begin
    if (reset) begin
      idx   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= control[0];
    end else if (state == RUN) begin
      idx   <= last ? '0 : idx + IW'(1);
      carry <= cout;
    end
  end

  // Result word fills from the MSB side, so after WIDTH shifts bit 0 lands at out[0]
  always_ff @(posedge clk) begin
    if (reset)              out <= '0;
    else if (state == RUN)  out <= {res, out[WIDTH-1:1]};
  end

  // Carry out of the MSB, captured on the final bit; logic ops report 0
  always_ff @(posedge clk) begin
    if (reset)                     carryout <= 1'b0;
    else if (accept)               carryout <= 1'b0;
    else if ((state == RUN) && last) carryout <= arith & cout;
  end

`ifdef BIT_SERIAL_ALU_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk) begin
    if (reset)                     overflow <= 1'b0;
    else if (accept)               overflow <= 1'b0;
    else if ((state == RUN) && last) overflow <= arith & (carry ^ cout);
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
